// File: rtl/trap_ctrl.sv
// Trap/exception controller: prioritises MEM-stage exceptions and interrupts, hands one code per
// trap to csr, then redirects the pipeline. Optional vectored interrupt targets: TRAP_VECTORED_EN.
module trap_ctrl #(
    parameter logic [4:0]  MTIME_ADDR     = 5'h1C,
    parameter logic [4:0]  MTIMECMP_ADDR  = 5'h1D,
    parameter int unsigned TIMER_PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        ov_i,
    input  logic        inst_invalid_i,
    input  logic        load_misalign_i,
    input  logic        store_misalign_i,
    input  logic        mret_i,
    input  logic        ext_int_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        csr_we_i,
    input  logic [4:0]  csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [4:0]  csr_raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        stall_req_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        timer_int_o
);

    localparam logic [31:0] CODE_EXT      = 32'd0;
    localparam logic [31:0] CODE_ECALL    = 32'd1;
    localparam logic [31:0] CODE_EBREAK   = 32'd2;
    localparam logic [31:0] CODE_TIMER    = 32'd3;
    localparam logic [31:0] CODE_OV       = 32'd4;
    localparam logic [31:0] CODE_INVALID  = 32'd5;
    localparam logic [31:0] CODE_LOAD_MIS = 32'd6;
    localparam logic [31:0] CODE_STORE_MIS= 32'd7;
    localparam logic [31:0] CODE_MRET     = 32'hFFFF_FFFF;
    localparam logic [31:0] CODE_NONE     = 32'h0000_00FF;
    localparam logic [31:0] PRESCALE_LAST = 32'(TIMER_PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT
    } state_t;

    state_t      state;
    logic        trap_hit;
    logic [31:0] trap_code;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic [31:0] pre_cnt;
    logic        tick;
    logic        wr_mtime;
    logic        wr_mtimecmp;

    // Only MIE and the mtvec mode bits are meaningful to this block.
    logic unused_csr_bits;
    assign unused_csr_bits = &{1'b0, mstatus_i[31:4], mstatus_i[2:0], mtvec_i[1:0]};

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        trap_hit  = 1'b0;
        trap_code = CODE_NONE;
        if (inst_valid_i) begin
            trap_hit = 1'b1;
            if (inst_invalid_i)        trap_code = CODE_INVALID;
            else if (ecall_i)          trap_code = CODE_ECALL;
            else if (ebreak_i)         trap_code = CODE_EBREAK;
            else if (load_misalign_i)  trap_code = CODE_LOAD_MIS;
            else if (store_misalign_i) trap_code = CODE_STORE_MIS;
            else if (ov_i)             trap_code = CODE_OV;
            else if (mret_i)           trap_code = CODE_MRET;
            else if (mstatus_i[3] && timer_int_o) trap_code = CODE_TIMER;
            else if (mstatus_i[3] && ext_int_i)   trap_code = CODE_EXT;
            else                       trap_hit  = 1'b0;
        end
    end

    assign trap_base = {mtvec_i[31:2], 2'b00};

    // In COMMIT, excepttype_o still holds the pending code and selects the target.
`ifdef TRAP_VECTORED_EN
    always_comb begin
        trap_target = trap_base;
        if (mtvec_i[1:0] == 2'b01) begin
            if (excepttype_o == CODE_TIMER)    trap_target = trap_base + 32'd28;
            else if (excepttype_o == CODE_EXT) trap_target = trap_base + 32'd44;
        end
    end
`else
    assign trap_target = trap_base;
`endif

    // NOTE: sequential state is updated with non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            excepttype_o        <= CODE_NONE;
            current_inst_addr_o <= '0;
            new_pc_o            <= '0;
            flush_o             <= 1'b0;
            stall_req_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_o <= 1'b0;
                    if (trap_hit) begin
                        excepttype_o        <= trap_code;
                        current_inst_addr_o <= inst_addr_i;
                        stall_req_o         <= 1'b1;
                        state               <= COMMIT;
                    end else begin
                        stall_req_o <= 1'b0;
                    end
                end
                COMMIT: begin
                    excepttype_o <= CODE_NONE;
                    flush_o      <= 1'b1;
                    stall_req_o  <= 1'b1;
                    new_pc_o     <= (excepttype_o == CODE_MRET) ? mepc_i : trap_target;
                    state        <= REDIRECT;
                end
                REDIRECT: begin
                    flush_o     <= 1'b0;
                    stall_req_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    excepttype_o <= CODE_NONE;
                    flush_o      <= 1'b0;
                    stall_req_o  <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign tick        = (pre_cnt == PRESCALE_LAST);
    assign wr_mtime    = csr_we_i && (csr_waddr_i == MTIME_ADDR);
    assign wr_mtimecmp = csr_we_i && (csr_waddr_i == MTIMECMP_ADDR);

    // Software writes take precedence over the free-running increment and the compare set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt     <= '0;
            mtime       <= '0;
            mtimecmp    <= '0;
            timer_int_o <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 32'd1;
            if (wr_mtime)  mtime <= csr_wdata_i;
            else if (tick) mtime <= mtime + 32'd1;
            if (wr_mtimecmp) mtimecmp <= csr_wdata_i;
            if (wr_mtimecmp)
                timer_int_o <= 1'b0;
            else if ((mtimecmp != 32'd0) && (mtime >= mtimecmp))
                timer_int_o <= 1'b1;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (csr_raddr_i == MTIME_ADDR)         rdata_o = mtime;
        else if (csr_raddr_i == MTIMECMP_ADDR) rdata_o = mtimecmp;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: priorities, FSM timing, interrupts, timer and reset.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_addr_i;
    logic        ecall_i, ebreak_i, ov_i, inst_invalid_i;
    logic        load_misalign_i, store_misalign_i, mret_i;
    logic        ext_int_i;
    logic [31:0] mstatus_i, mtvec_i, mepc_i;
    logic        csr_we_i;
    logic [4:0]  csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic [4:0]  csr_raddr_i;
    logic [31:0] rdata_o, excepttype_o, current_inst_addr_o, new_pc_o;
    logic        stall_req_o, flush_o, timer_int_o;

    int checks = 0;
    int errors = 0;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
        .ecall_i(ecall_i), .ebreak_i(ebreak_i), .ov_i(ov_i),
        .inst_invalid_i(inst_invalid_i), .load_misalign_i(load_misalign_i),
        .store_misalign_i(store_misalign_i), .mret_i(mret_i),
        .ext_int_i(ext_int_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .csr_raddr_i(csr_raddr_i), .rdata_o(rdata_o),
        .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
        .stall_req_o(stall_req_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [6:0] f);
        {inst_invalid_i, ecall_i, ebreak_i, load_misalign_i, store_misalign_i, ov_i, mret_i} = f;
    endtask

    task automatic idle_inputs();
        inst_valid_i = 1'b0;
        inst_addr_i  = '0;
        set_flags(7'b0);
        ext_int_i    = 1'b0;
        mstatus_i    = '0;
        mtvec_i      = 32'h80;
        mepc_i       = '0;
        csr_we_i     = 1'b0;
        csr_waddr_i  = '0;
        csr_wdata_i  = '0;
        csr_raddr_i  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        csr_raddr_i = 5'h1C;
        repeat (3) tick();
        checks++;
        if ({excepttype_o, current_inst_addr_o, new_pc_o} !== {32'hFF, 32'h0, 32'h0}) begin
            $display("FAIL reset_regs: type=%h addr=%h pc=%h want ff/0/0",
                     excepttype_o, current_inst_addr_o, new_pc_o);
            errors++;
        end
        checks++;
        if ({flush_o, stall_req_o, timer_int_o, rdata_o} !== {3'b000, 32'h0}) begin
            $display("FAIL reset_flags: flush=%b stall=%b tint=%b mtime=%h want 0/0/0/0",
                     flush_o, stall_req_o, timer_int_o, rdata_o);
            errors++;
        end
        rst = 1'b1;
    endtask

    task automatic test_ecall();
        do_reset();
        inst_valid_i = 1'b1; inst_addr_i = 32'h100; ecall_i = 1'b1; mtvec_i = 32'h80;
        tick();
        inst_valid_i = 1'b0; ecall_i = 1'b0;
        checks++;
        if ({excepttype_o, current_inst_addr_o, stall_req_o, flush_o} !== {32'd1, 32'h100, 2'b10}) begin
            $display("FAIL ecall_commit: type=%h addr=%h stall=%b flush=%b want 1/100/1/0",
                     excepttype_o, current_inst_addr_o, stall_req_o, flush_o);
            errors++;
        end
        tick();
        checks++;
        if ({excepttype_o, new_pc_o, stall_req_o, flush_o} !== {32'hFF, 32'h80, 2'b11}) begin
            $display("FAIL ecall_redirect: type=%h pc=%h stall=%b flush=%b want ff/80/1/1",
                     excepttype_o, new_pc_o, stall_req_o, flush_o);
            errors++;
        end
        tick();
        checks++;
        if ({stall_req_o, flush_o} !== 2'b00) begin
            $display("FAIL ecall_idle: stall=%b flush=%b want 0/0", stall_req_o, flush_o);
            errors++;
        end
    endtask

    task automatic test_priority();
        logic [6:0]  vec_flags [6] = '{7'b1000010, 7'b0110001, 7'b0011000,
                                       7'b0001100, 7'b0000110, 7'b0000011};
        logic [31:0] vec_code  [6] = '{32'd5, 32'd1, 32'd2, 32'd6, 32'd7, 32'd4};
        do_reset();
        // Bubble carrying a flag must not trap.
        ecall_i = 1'b1;
        repeat (2) tick();
        ecall_i = 1'b0;
        checks++;
        if ({excepttype_o, stall_req_o} !== {32'hFF, 1'b0}) begin
            $display("FAIL bubble_no_trap: type=%h stall=%b want ff/0", excepttype_o, stall_req_o);
            errors++;
        end
        // Interrupt pending and enabled, but sync flags still win; sync uses the base even if vectored.
        ext_int_i = 1'b1; mstatus_i = 32'h8; mtvec_i = 32'h81;
        for (int i = 0; i < 6; i++) begin
            inst_valid_i = 1'b1; inst_addr_i = 32'h200 + 32'(i * 4);
            set_flags(vec_flags[i]);
            tick();
            inst_valid_i = 1'b0; set_flags(7'b0);
            checks++;
            if ({excepttype_o, current_inst_addr_o} !== {vec_code[i], 32'h200 + 32'(i * 4)}) begin
                $display("FAIL prio_%0d: type=%h addr=%h want %h/%h", i, excepttype_o,
                         current_inst_addr_o, vec_code[i], 32'h200 + 32'(i * 4));
                errors++;
            end
            tick();
            checks++;
            if ({flush_o, new_pc_o} !== {1'b1, 32'h80}) begin
                $display("FAIL prio_redirect_%0d: flush=%b pc=%h want 1/80", i, flush_o, new_pc_o);
                errors++;
            end
            tick();
            checks++;
            if ({flush_o, stall_req_o, excepttype_o} !== {2'b00, 32'hFF}) begin
                $display("FAIL prio_single_flush_%0d: flush=%b stall=%b type=%h want 0/0/ff",
                         i, flush_o, stall_req_o, excepttype_o);
                errors++;
            end
        end
    endtask

    task automatic test_mret();
        do_reset();
        inst_valid_i = 1'b1; inst_addr_i = 32'h400; mret_i = 1'b1; mepc_i = 32'h204;
        tick();
        inst_valid_i = 1'b0; mret_i = 1'b0;
        checks++;
        if (excepttype_o !== 32'hFFFF_FFFF) begin
            $display("FAIL mret_commit: type=%h want ffffffff", excepttype_o);
            errors++;
        end
        tick();
        checks++;
        if ({flush_o, new_pc_o} !== {1'b1, 32'h204}) begin
            $display("FAIL mret_redirect: flush=%b pc=%h want 1/204", flush_o, new_pc_o);
            errors++;
        end
        tick();
    endtask

    task automatic test_flag_drop();
        do_reset();
        inst_valid_i = 1'b1; inst_addr_i = 32'h40; ecall_i = 1'b1;
        tick();
        ecall_i = 1'b0; ebreak_i = 1'b1;
        repeat (2) tick();
        inst_valid_i = 1'b0; ebreak_i = 1'b0;
        repeat (2) tick();
        checks++;
        if ({excepttype_o, stall_req_o, flush_o, current_inst_addr_o} !== {32'hFF, 2'b00, 32'h40}) begin
            $display("FAIL flag_drop: type=%h stall=%b flush=%b addr=%h want ff/0/0/40",
                     excepttype_o, stall_req_o, flush_o, current_inst_addr_o);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        inst_valid_i = 1'b1; inst_addr_i = 32'h10; ecall_i = 1'b1;
        tick();
        inst_valid_i = 1'b0; ecall_i = 1'b0;
        repeat (2) tick();
        inst_valid_i = 1'b1; inst_addr_i = 32'h14; ebreak_i = 1'b1;
        tick();
        inst_valid_i = 1'b0; ebreak_i = 1'b0;
        checks++;
        if ({excepttype_o, current_inst_addr_o, stall_req_o} !== {32'd2, 32'h14, 1'b1}) begin
            $display("FAIL back_to_back: type=%h addr=%h stall=%b want 2/14/1",
                     excepttype_o, current_inst_addr_o, stall_req_o);
            errors++;
        end
        repeat (2) tick();
    endtask

    task automatic test_ext_int();
        logic [31:0] exp_pc;
`ifdef TRAP_VECTORED_EN
        exp_pc = 32'hAC;
`else
        exp_pc = 32'h80;
`endif
        do_reset();
        ext_int_i = 1'b1; mstatus_i = 32'h0; mtvec_i = 32'h81;
        inst_valid_i = 1'b1; inst_addr_i = 32'h600;
        repeat (3) tick();
        checks++;
        if ({excepttype_o, stall_req_o} !== {32'hFF, 1'b0}) begin
            $display("FAIL ext_masked: type=%h stall=%b want ff/0", excepttype_o, stall_req_o);
            errors++;
        end
        mstatus_i = 32'h8;
        tick();
        inst_valid_i = 1'b0; ext_int_i = 1'b0;
        checks++;
        if ({excepttype_o, current_inst_addr_o} !== {32'd0, 32'h600}) begin
            $display("FAIL ext_taken: type=%h addr=%h want 0/600", excepttype_o, current_inst_addr_o);
            errors++;
        end
        tick();
        checks++;
        if ({flush_o, new_pc_o} !== {1'b1, exp_pc}) begin
            $display("FAIL ext_redirect: flush=%b pc=%h want 1/%h", flush_o, new_pc_o, exp_pc);
            errors++;
        end
        tick();
    endtask

    task automatic test_timer();
        logic [31:0] exp_pc;
`ifdef TRAP_VECTORED_EN
        exp_pc = 32'h9C;
`else
        exp_pc = 32'h80;
`endif
        do_reset();
        mstatus_i = 32'h8; mtvec_i = 32'h81;
        csr_we_i = 1'b1; csr_waddr_i = 5'h1D; csr_wdata_i = 32'd5;
        tick();
        csr_waddr_i = 5'h1C; csr_wdata_i = 32'd0;
        tick();
        csr_we_i = 1'b0; csr_raddr_i = 5'h1C;
        repeat (5) tick();
        checks++;
        if ({rdata_o, timer_int_o} !== {32'd5, 1'b0}) begin
            $display("FAIL timer_before: mtime=%h tint=%b want 5/0", rdata_o, timer_int_o);
            errors++;
        end
        tick();
        csr_raddr_i = 5'h1D;
        #1;
        checks++;
        if ({rdata_o, timer_int_o} !== {32'd5, 1'b1}) begin
            $display("FAIL timer_rise: mtimecmp=%h tint=%b want 5/1", rdata_o, timer_int_o);
            errors++;
        end
        inst_valid_i = 1'b1; inst_addr_i = 32'h300;
        tick();
        inst_valid_i = 1'b0;
        checks++;
        if ({excepttype_o, current_inst_addr_o} !== {32'd3, 32'h300}) begin
            $display("FAIL timer_taken: type=%h addr=%h want 3/300", excepttype_o, current_inst_addr_o);
            errors++;
        end
        tick();
        checks++;
        if ({flush_o, new_pc_o} !== {1'b1, exp_pc}) begin
            $display("FAIL timer_redirect: flush=%b pc=%h want 1/%h", flush_o, new_pc_o, exp_pc);
            errors++;
        end
        tick();
        // Compare condition still true this cycle; the write must win.
        csr_we_i = 1'b1; csr_waddr_i = 5'h1D; csr_wdata_i = 32'h1000;
        tick();
        csr_we_i = 1'b0;
        checks++;
        if (timer_int_o !== 1'b0) begin
            $display("FAIL timer_clear: tint=%b want 0", timer_int_o);
            errors++;
        end
        tick();
        checks++;
        if ({timer_int_o, rdata_o} !== {1'b0, 32'h1000}) begin
            $display("FAIL timer_stay_clear: tint=%b mtimecmp=%h want 0/1000", timer_int_o, rdata_o);
            errors++;
        end
    endtask

    task automatic test_reset_mid_trap();
        do_reset();
        inst_valid_i = 1'b1; inst_addr_i = 32'h500; ecall_i = 1'b1;
        tick();
        checks++;
        if (excepttype_o !== 32'd1) begin
            $display("FAIL rst_mid_setup: type=%h want 1", excepttype_o);
            errors++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({excepttype_o, flush_o, stall_req_o, current_inst_addr_o} !== {32'hFF, 2'b00, 32'h0}) begin
            $display("FAIL rst_mid_trap: type=%h flush=%b stall=%b addr=%h want ff/0/0/0",
                     excepttype_o, flush_o, stall_req_o, current_inst_addr_o);
            errors++;
        end
        inst_valid_i = 1'b0; ecall_i = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({flush_o, stall_req_o, new_pc_o} !== {2'b00, 32'h0}) begin
            $display("FAIL rst_mid_after: flush=%b stall=%b pc=%h want 0/0/0",
                     flush_o, stall_req_o, new_pc_o);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_priority();
        test_mret();
        test_flag_drop();
        test_back_to_back();
        test_ext_int();
        test_timer();
        test_reset_mid_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
